airi5c_gpio_incond: RTL and testbench

AIRI5C_GPIO_INCOND -- requirements
Module: airi5c_gpio_incond

---
 rtl/airi5c_gpio_incond.sv | 94 +++++++++
 tb/tb_airi5c_gpio_incond.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/airi5c_gpio_incond.sv
// airi5c_gpio_incond: synchronized, debounced GPIO inputs with edge-detect interrupts behind an AHB-lite slave
// Ports:
//   clk, nreset         system clock, asynchronous active-low reset
//   pin_i               raw asynchronous pad inputs
//   gpio_o              synchronized, debounced pin values (feeds gpio_i of airi5c_gpio)
//   irq_o               level interrupt, high while any enabled pending bit is set
//   haddr..hwdata       AHB-lite slave request (hsize, hburst, hmastlock, hprot ignored)
//   hrdata, hready, hresp  AHB-lite slave response (always ready, always OKAY)
// Registers: +0x00 VALUE (RO), +0x04 IRQ_EN, +0x08 EDGE_SEL (1 = rising), +0x0C PENDING (W1C), +0x10 DEB_LIMIT
module airi5c_gpio_incond #(
    parameter logic [31:0] BASE_ADDR = 32'hC0000040,
    parameter int          WIDTH     = 8,
    parameter int          DEB_W     = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic             irq_o,
    input  logic [31:0]      haddr,
    input  logic             hwrite,
    input  logic [2:0]       hsize,
    input  logic [2:0]       hburst,
    input  logic             hmastlock,
    input  logic [3:0]       hprot,
    input  logic [1:0]       htrans,
    input  logic [31:0]      hwdata,
    output logic [31:0]      hrdata,
    output logic             hready,
    output logic             hresp
);
    localparam logic [31:0] A_VALUE   = BASE_ADDR;
    localparam logic [31:0] A_IRQ_EN  = BASE_ADDR + 32'h04;
    localparam logic [31:0] A_EDGE    = BASE_ADDR + 32'h08;
    localparam logic [31:0] A_PENDING = BASE_ADDR + 32'h0C;
    localparam logic [31:0] A_DEB     = BASE_ADDR + 32'h10;

    logic [WIDTH-1:0] meta, sync, stable, irq_en, edge_sel, pending, load, ev, clr;
    logic [DEB_W-1:0] cnt [WIDTH];
    logic [DEB_W-1:0] deb_limit;
    logic [31:0]      addr_q, rdata;
    logic             write_q, active, unused;

    assign active = htrans != 2'b00;
    assign gpio_o = stable;
    assign irq_o  = |(pending & irq_en);
    assign hready = 1'b1;
    assign hresp  = 1'b0;
    assign unused = &{1'b0, hsize, hburst, hmastlock, hprot, hwdata};

    always_comb begin
        load = '0;
        for (int i = 0; i < WIDTH; i++)
            load[i] = (sync[i] != stable[i]) && (cnt[i] >= deb_limit);
        // sync is the value stable is about to take, so it names the edge direction
        ev = load & ~(sync ^ edge_sel);
        clr = (write_q && addr_q == A_PENDING) ? hwdata[WIDTH-1:0] : '0;
        rdata = haddr == A_VALUE   ? 32'(stable)   :
                haddr == A_IRQ_EN  ? 32'(irq_en)   :
                haddr == A_EDGE    ? 32'(edge_sel) :
                haddr == A_PENDING ? 32'(pending)  :
                haddr == A_DEB     ? 32'(deb_limit) : '0;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            meta      <= '0;
            sync      <= '0;
            stable    <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
            irq_en    <= '0;
            edge_sel  <= '1;
            pending   <= '0;
            deb_limit <= '0;
            hrdata    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
        end else begin
            meta   <= pin_i;
            sync   <= meta;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= (sync[i] == stable[i] || load[i]) ? '0 : cnt[i] + DEB_W'(1);
            stable <= stable ^ load;
            // a new event outranks a simultaneous write-1-to-clear
            pending <= (pending & ~clr) | ev;
            write_q <= active && hwrite;
            if (active) addr_q <= haddr;
            if (active && !hwrite) hrdata <= rdata;
            if (write_q && addr_q == A_IRQ_EN) irq_en <= hwdata[WIDTH-1:0];
            if (write_q && addr_q == A_EDGE) edge_sel <= hwdata[WIDTH-1:0];
            if (write_q && addr_q == A_DEB) deb_limit <= hwdata[DEB_W-1:0];
        end
    end
endmodule

// File: tb/tb_airi5c_gpio_incond.sv
// tb_airi5c_gpio_incond: directed, table-driven and randomized checks of airi5c_gpio_incond
module tb_airi5c_gpio_incond;
    localparam logic [31:0] BASE = 32'hC0000040;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [7:0]  pin_i = '0;
    logic [7:0]  gpio_o;
    logic        irq_o;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = 3'd0;
    logic        hmastlock = 1'b0;
    logic [3:0]  hprot = 4'd3;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata;
    logic        hready, hresp;

    int pass = 0;
    int total = 0;

    airi5c_gpio_incond dut (
        .clk(clk), .nreset(nreset), .pin_i(pin_i), .gpio_o(gpio_o), .irq_o(irq_o),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    // Reference model: pins reach the debouncer two clocks late; a bit of gpio_o
    // follows once the delayed pin has disagreed with it for more than DEB_LIMIT
    // consecutive clocks. Registers written by the bus tasks live in m_ien/m_esel/m_lim.
    logic [7:0] m_meta, m_sync, m_stable, m_pend, m_ev;
    logic [7:0] m_ien = '0, m_esel = '1, m_clr = '0;
    int         m_lim = 0;
    int         run [8];

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_meta = '0; m_sync = '0; m_stable = '0; m_pend = '0;
            for (int i = 0; i < 8; i++) run[i] = 0;
        end else begin
            m_ev = '0;
            for (int i = 0; i < 8; i++) begin
                if (m_sync[i] != m_stable[i]) begin
                    run[i]++;
                    if (run[i] > m_lim) begin
                        m_stable[i] = m_sync[i];
                        run[i] = 0;
                        if (m_sync[i] == m_esel[i]) m_ev[i] = 1'b1;
                    end
                end else run[i] = 0;
            end
            m_pend = (m_pend & ~m_clr) | m_ev;
            m_sync = m_meta;
            m_meta = pin_i;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        haddr = a; hwrite = 1'b1; htrans = 2'b10;
        tick;
        htrans = 2'b00; hwrite = 1'b0; hwdata = d;
        if (a == BASE + 32'h0C) m_clr = d[7:0];
        tick;
        m_clr = '0;
        if (a == BASE + 32'h04) m_ien = d[7:0];
        if (a == BASE + 32'h08) m_esel = d[7:0];
        if (a == BASE + 32'h10) m_lim = int'(d[15:0]);
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        haddr = a; hwrite = 1'b0; htrans = 2'b10;
        tick;
        htrans = 2'b00;
        d = hrdata;
    endtask

    typedef struct {
        logic [31:0] wa;
        logic        wr;
        logic [31:0] d;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [10];

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] v, e;
        tbl[0] = '{BASE + 32'h04, 1'b1, 32'h000000A5, BASE + 32'h04, 32'h000000A5};
        tbl[1] = '{BASE + 32'h08, 1'b1, 32'h0000003C, BASE + 32'h08, 32'h0000003C};
        tbl[2] = '{BASE + 32'h10, 1'b1, 32'h000ABCDE, BASE + 32'h10, 32'h0000BCDE};
        tbl[3] = '{BASE + 32'h04, 1'b1, 32'h000001FF, BASE + 32'h04, 32'h000000FF};
        tbl[4] = '{BASE + 32'h00, 1'b1, 32'h000000FF, BASE + 32'h00, 32'h00000000};
        tbl[5] = '{BASE + 32'h14, 1'b1, 32'h00000055, BASE + 32'h14, 32'h00000000};
        tbl[6] = '{BASE + 32'h20, 1'b0, 32'h00000000, BASE + 32'h20, 32'h00000000};
        tbl[7] = '{BASE + 32'h0C, 1'b1, 32'h000000FF, BASE + 32'h0C, 32'h00000000};
        tbl[8] = '{BASE + 32'h05, 1'b1, 32'h00000011, BASE + 32'h04, 32'h000000FF};
        tbl[9] = '{BASE + 32'h00, 1'b0, 32'h00000000, BASE + 32'h08, 32'h0000003C};

        repeat (3) tick;
        nreset = 1'b1;
        tick;
        chk("reset gpio_o", 32'(gpio_o), 0);
        chk("reset irq_o", 32'(irq_o), 0);
        chk("reset hrdata", hrdata, 0);
        bus_rd(BASE + 32'h08, v); chk("reset EDGE_SEL", v, 32'hFF);
        bus_rd(BASE + 32'h10, v); chk("reset DEB_LIMIT", v, 0);
        bus_rd(BASE + 32'h0C, v); chk("reset PENDING", v, 0);

        for (int k = 0; k < 10; k++) begin
            if (tbl[k].wr) bus_wr(tbl[k].wa, tbl[k].d);
            bus_rd(tbl[k].ra, v);
            chk($sformatf("table[%0d] rdata", k), v, tbl[k].exp);
            chk($sformatf("table[%0d] hready", k), 32'(hready), 1);
            chk($sformatf("table[%0d] hresp", k), 32'(hresp), 0);
        end
        bus_wr(BASE + 32'h08, 32'hFF);
        bus_wr(BASE + 32'h10, 32'h0);
        bus_wr(BASE + 32'h04, 32'h01);

        // DEB_LIMIT = 0: change visible on the third edge, pending on the same edge
        pin_i[0] = 1'b1;
        tick; tick;
        chk("lim0 gpio_o cycle2", 32'(gpio_o[0]), 0);
        chk("lim0 irq_o cycle2", 32'(irq_o), 0);
        tick;
        chk("lim0 gpio_o cycle3", 32'(gpio_o[0]), 1);
        chk("lim0 irq_o cycle3", 32'(irq_o), 1);
        bus_wr(BASE + 32'h0C, 32'h01);
        chk("lim0 irq cleared", 32'(irq_o), 0);

        // DEB_LIMIT = 5: 4-cycle glitch rejected, held level accepted at cycle 8
        bus_wr(BASE + 32'h10, 32'd5);
        pin_i[3] = 1'b1;
        repeat (4) tick;
        pin_i[3] = 1'b0;
        repeat (14) tick;
        chk("glitch gpio_o", 32'(gpio_o), 32'h01);
        bus_rd(BASE + 32'h0C, v); chk("glitch PENDING", v, 0);
        pin_i[3] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            chk($sformatf("lim5 gpio_o[3] cycle%0d", k), 32'(gpio_o[3]), (k >= 8) ? 1 : 0);
        end
        bus_rd(BASE + 32'h0C, v); chk("lim5 PENDING", v, 32'h08);

        // falling-edge interrupt and its W1C clear
        bus_wr(BASE + 32'h08, 32'h00);
        bus_wr(BASE + 32'h10, 32'h0);
        bus_wr(BASE + 32'h0C, 32'hFF);
        pin_i[0] = 1'b0;
        tick; tick;
        chk("fall irq_o cycle2", 32'(irq_o), 0);
        tick;
        chk("fall gpio_o[0]", 32'(gpio_o[0]), 0);
        chk("fall irq_o cycle3", 32'(irq_o), 1);
        haddr = BASE + 32'h0C; hwrite = 1'b1; htrans = 2'b10;
        tick;
        htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h01; m_clr = 8'h01;
        chk("w1c irq_o data phase", 32'(irq_o), 1);
        tick;
        m_clr = '0;
        chk("w1c irq_o after", 32'(irq_o), 0);

        // rising event and clear on the same edge: set wins
        bus_wr(BASE + 32'h08, 32'h01);
        m_esel = 8'h01;
        pin_i[0] = 1'b1;
        tick;
        haddr = BASE + 32'h0C; hwrite = 1'b1; htrans = 2'b10;
        tick;
        htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h01; m_clr = 8'h01;
        tick;
        m_clr = '0;
        chk("set-wins irq_o", 32'(irq_o), 1);
        bus_rd(BASE + 32'h0C, v); chk("set-wins PENDING", v, 32'h01);

        // write then immediate read of the same register returns the old value
        haddr = BASE + 32'h04; hwrite = 1'b1; htrans = 2'b10;
        tick;
        hwdata = 32'h5A; hwrite = 1'b0;
        tick;
        htrans = 2'b00;
        m_ien = 8'h5A;
        chk("b2b old IRQ_EN", hrdata, 32'h01);
        bus_rd(BASE + 32'h04, v); chk("b2b new IRQ_EN", v, 32'h5A);

        // reset in the middle of a long debounce
        bus_wr(BASE + 32'h10, 32'd100);
        pin_i[5] = 1'b1;
        repeat (20) tick;
        #2;
        nreset = 1'b0;
        m_ien = '0; m_esel = '1; m_lim = 0;
        #1;
        chk("mid-reset gpio_o", 32'(gpio_o), 0);
        chk("mid-reset hrdata", hrdata, 0);
        chk("mid-reset irq_o", 32'(irq_o), 0);
        chk("mid-reset hready", 32'(hready), 1);
        pin_i = '0;
        repeat (3) tick;
        nreset = 1'b1;
        repeat (5) tick;
        chk("post-reset gpio_o", 32'(gpio_o), 0);
        chk("post-reset irq_o", 32'(irq_o), 0);
        bus_rd(BASE + 32'h10, v); chk("post-reset DEB_LIMIT", v, 0);
        bus_rd(BASE + 32'h08, v); chk("post-reset EDGE_SEL", v, 32'hFF);
        bus_rd(BASE + 32'h04, v); chk("post-reset IRQ_EN", v, 0);
        bus_rd(BASE + 32'h0C, v); chk("post-reset PENDING", v, 0);

        // randomized pins against the reference model
        bus_wr(BASE + 32'h04, 32'hFF);
        for (int b = 0; b < 4; b++) begin
            bus_wr(BASE + 32'h10, 32'($urandom_range(0, 3)));
            bus_wr(BASE + 32'h08, 32'($urandom_range(0, 255)));
            for (int c = 0; c < 100; c++) begin
                for (int i = 0; i < 8; i++)
                    if ($urandom_range(0, 3) == 0) pin_i[i] = ~pin_i[i];
                tick;
                chk($sformatf("rand gpio_o b%0d c%0d", b, c), 32'(gpio_o), 32'(m_stable));
                chk($sformatf("rand irq_o b%0d c%0d", b, c), 32'(irq_o), 32'(|(m_pend & m_ien)));
            end
            e = 32'(m_pend);
            bus_rd(BASE + 32'h0C, v);
            chk($sformatf("rand PENDING b%0d", b), v, e);
            bus_wr(BASE + 32'h0C, 32'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
